// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 Set 2 scan-code decoder: FSM states,
// prefix byte values and status-byte classification.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE_ST    = 3'd0,
        EXT_ST     = 3'd1,
        BRK_ST     = 3'd2,
        EXT_BRK_ST = 3'd3,
        PAUSE_ST   = 3'd4
    } state_e;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam int unsigned PAUSE_SKIP = 7;
    localparam logic [8:0] KEY_PAUSE  = 9'h1E1;

    // Keyboard replies (self-test, ack, resend, errors) that carry no key event.
    function automatic logic is_status_byte(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

endpackage

// File: rtl/kbd_timeout.sv
// Inter-byte gap counter: pulses expired when a sequence has been idle for
// TIMEOUT_CYCLES cycles.
module kbd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        expired = enable && !clear && (count_q == LAST);
        if (!enable || clear || expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scancode_dec.sv
// PS/2 Set 2 scan-code decoder: folds E0/F0/E1 prefix sequences into one
// 9-bit key code with registered make/brake/seq_err pulses.
module scancode_dec
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brake,
    output logic       seq_err
);

    state_e     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic [8:0] key_q, key_d;
    logic       make_q, make_d;
    logic       brake_q, brake_d;
    logic       err_q, err_d;
    logic       expired;

    kbd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetN (resetN),
        .enable (state_q != IDLE_ST),
        .clear  (din_new),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        key_d   = key_q;
        make_d  = 1'b0;
        brake_d = 1'b0;
        err_d   = 1'b0;
        if (din_new) begin
            case (state_q)
                IDLE_ST: begin
                    if (din == PFX_EXT) begin
                        state_d = EXT_ST;
                    end else if (din == PFX_BRK) begin
                        state_d = BRK_ST;
                    end else if (din == PFX_PAUSE) begin
                        state_d = PAUSE_ST;
                        skip_d  = 3'(PAUSE_SKIP);
                    end else if (!is_status_byte(din)) begin
                        key_d  = {1'b0, din};
                        make_d = 1'b1;
                    end
                end
                EXT_ST: begin
                    if (din == PFX_BRK) begin
                        state_d = EXT_BRK_ST;
                    end else if (din == PFX_EXT) begin
                        state_d = EXT_ST;
                    end else if (din == PFX_PAUSE || is_status_byte(din)) begin
                        err_d   = 1'b1;
                        state_d = IDLE_ST;
                    end else begin
                        key_d   = {1'b1, din};
                        make_d  = 1'b1;
                        state_d = IDLE_ST;
                    end
                end
                BRK_ST, EXT_BRK_ST: begin
                    if (din == PFX_EXT) begin
                        // A stray E0 is taken as the start of a new extended sequence.
                        err_d   = 1'b1;
                        state_d = EXT_ST;
                    end else if (din == PFX_BRK) begin
                        err_d = 1'b1;
                    end else if (din == PFX_PAUSE || is_status_byte(din)) begin
                        err_d   = 1'b1;
                        state_d = IDLE_ST;
                    end else begin
                        key_d   = {state_q == EXT_BRK_ST, din};
                        brake_d = 1'b1;
                        state_d = IDLE_ST;
                    end
                end
                PAUSE_ST: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        key_d   = KEY_PAUSE;
                        make_d  = 1'b1;
                        state_d = IDLE_ST;
                    end
                end
                default: state_d = IDLE_ST;
            endcase
        end else if (expired) begin
            err_d   = 1'b1;
            state_d = IDLE_ST;
            skip_d  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE_ST;
            skip_q  <= 3'd0;
            key_q   <= 9'h000;
            make_q  <= 1'b0;
            brake_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            key_q   <= key_d;
            make_q  <= make_d;
            brake_q <= brake_d;
            err_q   <= err_d;
        end
    end

    assign keyCode = key_q;
    assign make    = make_q;
    assign brake   = brake_q;
    assign seq_err = err_q;

endmodule

// File: tb/tb_scancode_dec.sv
// Directed and randomized bench for scancode_dec against a prefix-flag
// reference model of the PS/2 Set 2 decoding rules.
module tb_scancode_dec;

    localparam int unsigned T = 100;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_new = 1'b0;
    logic [8:0] keyCode;
    logic       make, brake, seq_err;

    scancode_dec #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .din    (din),
        .din_new(din_new),
        .keyCode(keyCode),
        .make   (make),
        .brake  (brake),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    string tag = "reset";

    // Reference model: pending prefixes as flags plus bytes left to skip.
    bit         m_ext, m_brk;
    int         m_pause, m_cnt;
    bit         e_make, e_brake, e_err;
    logic [8:0] e_key;

    logic [7:0] status_tab [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    function automatic bit is_status(input logic [7:0] b);
        for (int i = 0; i < 7; i++) if (status_tab[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_ext = 0; m_brk = 0; m_pause = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin e_make = 1; e_key = 9'h1E1; end
        end else if (b == 8'hE1 || is_status(b)) begin
            if (m_ext || m_brk) begin e_err = 1; model_clear(); end
            else if (b == 8'hE1) m_pause = 7;
        end else if (b == 8'hE0) begin
            if (m_brk) e_err = 1;
            m_ext = 1; m_brk = 0;
        end else if (b == 8'hF0) begin
            if (m_brk) e_err = 1;
            m_brk = 1;
        end else begin
            if (m_brk) e_brake = 1; else e_make = 1;
            e_key = {m_ext, b};
            model_clear();
        end
    endtask

    task automatic model_step(input bit nw, input logic [7:0] b);
        e_make = 0; e_brake = 0; e_err = 0;
        if (nw) begin
            model_byte(b);
            m_cnt = 0;
        end else if (m_ext || m_brk || m_pause > 0) begin
            if (m_cnt == T - 1) begin e_err = 1; model_clear(); end
            else m_cnt++;
        end else begin
            m_cnt = 0;
        end
    endtask

    task automatic check();
        tests++;
        assert ({make, brake, seq_err, keyCode} === {e_make, e_brake, e_err, e_key})
        else begin
            fails++;
            $error("FAIL %s obs m/b/e/key=%b%b%b/%h exp=%b%b%b/%h", tag, make, brake,
                   seq_err, keyCode, e_make, e_brake, e_err, e_key);
        end
    endtask

    task automatic check_val(input string name, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", name, obs, exp);
        end
    endtask

    task automatic step(input bit nw, input logic [7:0] b);
        din = b;
        din_new = nw;
        model_step(nw, b);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send_spaced(input logic [7:0] b);
        step(1'b1, b);
        idle(99);
    endtask

    initial begin
        model_clear();
        e_make = 0; e_brake = 0; e_err = 0; e_key = 9'h000;
        #2;
        check();
        @(posedge clk); #1;
        check();
        resetN = 1'b1;
        idle(3);

        tag = "make_brk_1D";
        send_spaced(8'h1D);
        send_spaced(8'hF0);
        step(1'b1, 8'h1D);
        check_val("brk_1D_key", {1'b0, brake, seq_err, keyCode}, {3'b010, 9'h01D});
        idle(99);

        tag = "ext_75";
        step(1'b1, 8'hE0); step(1'b1, 8'h75);
        check_val("make_175", {make, brake, seq_err, keyCode}, {3'b100, 9'h175});
        idle(4);
        step(1'b1, 8'hE0); step(1'b1, 8'hF0); step(1'b1, 8'h75);
        check_val("brk_175", {make, brake, seq_err, keyCode}, {3'b010, 9'h175});
        idle(4);

        tag = "pause";
        step(1'b1, 8'hE1); step(1'b1, 8'h14); step(1'b1, 8'h77); step(1'b1, 8'hE1);
        step(1'b1, 8'hF0); step(1'b1, 8'h14); step(1'b1, 8'hF0); step(1'b1, 8'h77);
        check_val("pause_key", {make, brake, seq_err, keyCode}, {3'b100, 9'h1E1});
        idle(4);

        tag = "status";
        step(1'b1, 8'hAA); idle(2); step(1'b1, 8'hFA); idle(2);
        step(1'b1, 8'hF0); step(1'b1, 8'hE0);
        check_val("f0_e0_err", {make, brake, seq_err, keyCode}, {3'b001, 9'h1E1});
        step(1'b1, 8'h29);
        check_val("make_129", {make, brake, seq_err, keyCode}, {3'b100, 9'h129});
        idle(3);

        tag = "timeout";
        step(1'b1, 8'hE0);
        idle(T);
        check_val("timeout_err", {11'd0, seq_err}, 12'd1);
        step(1'b1, 8'h1C);
        check_val("after_to_1C", {make, brake, seq_err, keyCode}, {3'b100, 9'h01C});
        idle(3);

        tag = "byte_wins";
        step(1'b1, 8'hF0);
        idle(T - 1);
        step(1'b1, 8'h33);
        check_val("byte_wins", {make, brake, seq_err, keyCode}, {3'b010, 9'h033});
        idle(T + 2);

        tag = "reset_mid";
        step(1'b1, 8'hE0); step(1'b1, 8'hF0);
        din_new = 1'b0;
        resetN = 1'b0;
        model_clear();
        e_make = 0; e_brake = 0; e_err = 0; e_key = 9'h000;
        #2;
        check();
        @(posedge clk); #1;
        check();
        resetN = 1'b1;
        idle(5);
        step(1'b1, 8'h1C);
        check_val("rst_1C", {make, brake, seq_err, keyCode}, {3'b100, 9'h01C});
        idle(3);

        tag = "random";
        for (int n = 0; n < 400; n++) begin
            int unsigned kind;
            logic [7:0]  b;
            int unsigned g;
            kind = $urandom_range(0, 9);
            case (kind)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'hE1;
                3: b = status_tab[$urandom_range(0, 6)];
                default: b = 8'($urandom);
            endcase
            step(1'b1, b);
            g = $urandom_range(0, 15);
            if (g == 0) idle($urandom_range(T - 2, T + 1));
            else if (g < 8) idle(g - 1);
        end
        idle(T + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
